bus_rr_arbiter: RTL and testbench
=================================

Name: bus_rr_arbiter

Overview:
- Shares one valid/ready byte bus between NUM_SRC requesters.
- Round-robin grant with packet lock: a granted source owns the bus until it transfers a beat with last set, or until a beat-limit watchdog forces release.
- Sits between multiple bus masters and a single sink using the team's valid/ready handshake: a beat transfers on a clk rising edge where valid && ready.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_W, 8, data width per beat.
- MAX_BEATS, 16, beats allowed in one grant before forced release (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  NUM_SRC  per-source valid.
- s_data  in  NUM_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
- s_last  in  NUM_SRC  per-source last-beat flag.
- s_ready  out  NUM_SRC  per-source ready.
- m_valid  out  1  valid to sink.
- m_data  out  DATA_W  data to sink.
- m_last  out  1  last to sink.
- m_ready  in  1  sink ready.
- grant_id  out  $clog2(NUM_SRC)  index of the owning source; meaningful only while busy=1.
- busy  out  1  a grant is held.
- err_timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0, err_timeout=0. Outputs while in reset: s_ready=0, m_valid=0, m_data=0, m_last=0.
- States: IDLE, BUSY.
- IDLE: busy=0, m_valid=0, m_data=0, m_last=0, all s_ready=0.
  - If any s_valid=1: winner = first i with s_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - Next edge: grant_id<=winner, beat_cnt<=0, state<=BUSY.
  - Arbitration cost: exactly 1 cycle. The first beat can transfer no earlier than the cycle after the request is seen.
- BUSY, combinational steering from grant g=grant_id:
  - m_valid=s_valid[g], m_data=s_data[g], m_last=s_last[g].
  - s_ready[g]=m_ready; all other s_ready=0.
  - busy=1.
- Beat accepted = m_valid && m_ready.
  - On accept with m_last=1: state<=IDLE, rr_ptr<=(g+1) mod NUM_SRC, beat_cnt<=0.
  - On accept with m_last=0: beat_cnt<=beat_cnt+1.
  - If that increment makes beat_cnt reach MAX_BEATS:
    - err_timeout=1 for the next cycle only.
    - state<=IDLE, rr_ptr<=(g+1) mod NUM_SRC.
    - The remainder of the packet competes again as a new request.
- Granted source dropping s_valid mid-packet: grant is held, m_valid=0, no timeout. The watchdog counts accepted beats only, not cycles.
- Non-granted sources are never ready; their valid may stay high indefinitely without effect.
- After every release, IDLE lasts exactly 1 cycle (one bus bubble) before the next grant.
- rr_ptr updates only on release, so a single continuous requester is regranted every 2nd cycle after each packet.
- Widths: beat_cnt is 8 bits; rr_ptr and grant_id are $clog2(NUM_SRC) bits with explicit mod wrap for non-power-of-2 NUM_SRC.
- Reset asserted mid-packet: immediate return to the reset state; the partial packet is abandoned with no error pulse.
- m_data is 0 whenever m_valid=0 in IDLE. In BUSY, m_data follows the granted source's data regardless of valid.

Test Plan:
- Single source: src1 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33), m_ready=1.
  - Required: grant_id=1 from cycle 2.
  - Required: m_data sequence 0x11, 0x22, 0x33 on consecutive cycles, then busy=0 for 1 cycle; rr_ptr=2.
- Round-robin fairness: all 4 sources request 1-beat packets continuously from reset.
  - Required: grant order 0, 1, 2, 3, 0, each grant separated by one idle cycle.
  - Required: no source is granted twice while another source is waiting.
- Packet lock: src0 holds a 4-beat packet and src2 requests at beat 2.
  - Required: src2 sees s_ready=0 until src0's last beat is accepted; src2 is granted 1 cycle later.
- Backpressure: m_ready toggles 1, 0, 1, 0 during a 3-beat packet from src3.
  - Required: each beat is held stable and accepted only when m_ready=1.
  - Required: s_ready[3]==m_ready every cycle; no beat is lost or duplicated.
- Watchdog: MAX_BEATS=4, src2 streams beats with s_last=0 (src2 has no stricter requirement here).
  - Required: after the 4th accepted beat, err_timeout pulses for 1 cycle and busy drops.
  - Required: src3 (requesting) is granted next.
- Reset mid-packet: assert rst_n=0 during beat 2 of a src1 packet.
  - Required: outputs go to 0 immediately, grant_id=0.
  - Required: after release, src0 wins if it is requesting alongside src1.

Source files
------------

// File: rtl/bus_rr_arbiter_if.sv
// Shared valid/ready byte bus between NUM_SRC requesters and one sink, plus arbiter status.
// Handshake: a beat transfers on a rising clk edge where valid && ready; valid never waits on ready.
interface bus_rr_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8
);
    localparam int IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]        s_valid;
    logic [NUM_SRC*DATA_W-1:0] s_data;
    logic [NUM_SRC-1:0]        s_last;
    logic [NUM_SRC-1:0]        s_ready;
    logic                      m_valid;
    logic [DATA_W-1:0]         m_data;
    logic                      m_last;
    logic                      m_ready;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;
    logic                      err_timeout;

    // master: the environment (sources and sink); slave: the arbiter itself
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, grant_id, busy, err_timeout
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter with packet lock and a beat-count watchdog; one idle
// bubble between grants, pointer advances past the owner on every release.
module bus_rr_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    bus_rr_arbiter_if.slave            bus,
    output logic                       dbg_state_o,
    output logic [$clog2(NUM_SRC)-1:0] dbg_rr_ptr_o
);
    localparam int         IDX_W = $clog2(NUM_SRC);
    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic               err_q, err_d;

    logic [IDX_W:0]     pick;
    logic [IDX_W-1:0]   next_ptr;
    logic               accept;
    logic [NUM_SRC-1:0] s_ready;
    logic               m_valid;
    logic               m_last;
    logic [DATA_W-1:0]  m_data;

    // Returns {found, index}: first requester at or after ptr, wrapping mod NUM_SRC.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (req[idx]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    assign pick     = rr_pick(bus.s_valid, rr_ptr_q);
    assign next_ptr = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = 1'b0;
        s_ready    = '0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick[IDX_W]) begin
                    grant_d    = pick[IDX_W-1:0];
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                m_valid          = bus.s_valid[grant_q];
                m_data           = bus.s_data[grant_q*DATA_W +: DATA_W];
                m_last           = bus.s_last[grant_q];
                s_ready[grant_q] = bus.m_ready;
                accept           = m_valid && bus.m_ready;
                if (accept) begin
                    if (m_last) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_ptr;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        // A finishing last beat wins over the watchdog on the same transfer.
                        if (beat_cnt_q + 8'd1 == MAX_B) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_ptr;
                            err_d    = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_ready     = s_ready;
    assign bus.m_valid     = m_valid;
    assign bus.m_data      = m_data;
    assign bus.m_last      = m_last;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = (state_q == BUSY);
    assign bus.err_timeout = err_q;
    assign dbg_state_o     = state_q;
    assign dbg_rr_ptr_o    = rr_ptr_q;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: per-source beat queues, a grant-level reference model
// compared every cycle, a per-source data scoreboard, and directed literal checks.
module tb_bus_rr_arbiter;
    localparam int NUM_SRC   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BEATS = 4;
    localparam int IDX_W     = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_rr_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) bus ();
    logic             dbg_state;
    logic [IDX_W-1:0] dbg_rr_ptr;

    bus_rr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .dbg_state_o  (dbg_state),
        .dbg_rr_ptr_o (dbg_rr_ptr)
    );

    int n_vec;
    int n_miss;
    int cyc;
    int n_pushed;
    int n_popped;

    logic [DATA_W:0] src_q [NUM_SRC][$];
    logic [DATA_W:0] exp_q [NUM_SRC][$];
    bit              gap [NUM_SRC];

    // Reference model: who owns the bus, rotation pointer, beats in this grant, pending error pulse.
    int mdl_owner;
    int mdl_ptr;
    int mdl_cnt;
    bit mdl_err;

    logic [7:0] b_tab [3]   = '{8'h11, 8'h22, 8'h33};
    int         c_order [5] = '{0, 1, 2, 3, 0};
    bit         e_rdy [5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] e_dat [5]   = '{8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mdl_owner = -1;
        mdl_ptr   = 0;
        mdl_cnt   = 0;
        mdl_err   = 1'b0;
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM_SRC; i++)
            if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_beat(input int s, input logic [7:0] d, input bit last);
        src_q[s].push_back({last, d});
        exp_q[s].push_back({last, d});
        n_pushed++;
    endtask

    task automatic add_rand_pkt(input int s, input int len);
        for (int b = 0; b < len; b++) add_beat(s, 8'($urandom), (b == len - 1));
    endtask

    task automatic drive();
        logic [NUM_SRC-1:0]        v;
        logic [NUM_SRC-1:0]        l;
        logic [NUM_SRC*DATA_W-1:0] d;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() != 0 && !gap[i]) begin
                v[i]                   = 1'b1;
                d[i*DATA_W +: DATA_W]  = src_q[i][0][DATA_W-1:0];
                l[i]                   = src_q[i][0][DATA_W];
            end else begin
                v[i]                   = 1'b0;
                d[i*DATA_W +: DATA_W]  = 8'($urandom);
                l[i]                   = 1'($urandom);
            end
        end
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_last  = l;
    endtask

    // Outputs the arbiter must show this cycle, given the model's ownership and current inputs.
    task automatic compare_model();
        logic [NUM_SRC-1:0] e_ready;
        logic               e_valid;
        logic               e_last;
        logic [DATA_W-1:0]  e_data;
        logic               e_busy;
        e_ready = '0;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_data  = '0;
        e_busy  = 1'b0;
        if (rst_n && mdl_owner >= 0) begin
            e_busy             = 1'b1;
            e_valid            = bus.s_valid[mdl_owner];
            e_last             = bus.s_last[mdl_owner];
            e_data             = bus.s_data[mdl_owner*DATA_W +: DATA_W];
            e_ready[mdl_owner] = bus.m_ready;
            chk("grant_id", 32'(bus.grant_id), mdl_owner);
        end
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("m_valid", 32'(bus.m_valid), 32'(e_valid));
        chk("m_data", 32'(bus.m_data), 32'(e_data));
        chk("m_last", 32'(bus.m_last), 32'(e_last));
        chk("s_ready", 32'(bus.s_ready), 32'(e_ready));
        chk("err_timeout", 32'(bus.err_timeout), 32'(rst_n && mdl_err));
    endtask

    task automatic settle();
        drive();
        #2;
        compare_model();
    endtask

    task automatic advance();
        logic [DATA_W:0] e;
        logic [DATA_W:0] beat;
        int              g;
        bit              nerr;
        bit              found;
        int              idx;
        if (rst_n && bus.busy && bus.m_valid && bus.m_ready) begin
            g = int'(bus.grant_id);
            if (exp_q[g].size() == 0) begin
                chk("sb_spurious_beat", 32'(g), 32'hFFFF_FFFF);
            end else begin
                e = exp_q[g].pop_front();
                n_popped++;
                chk("sb_beat", 32'({bus.m_last, bus.m_data}), 32'(e));
            end
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            nerr = 1'b0;
            if (mdl_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < NUM_SRC; k++) begin
                    idx = (mdl_ptr + k) % NUM_SRC;
                    if (!found && bus.s_valid[idx]) begin
                        found     = 1'b1;
                        mdl_owner = idx;
                        mdl_cnt   = 0;
                    end
                end
            end else if (bus.s_valid[mdl_owner] && bus.m_ready) begin
                beat = src_q[mdl_owner].pop_front();
                if (beat[DATA_W]) begin
                    mdl_ptr   = (mdl_owner + 1) % NUM_SRC;
                    mdl_owner = -1;
                end else begin
                    mdl_cnt++;
                    if (mdl_cnt == MAX_BEATS) begin
                        mdl_ptr   = (mdl_owner + 1) % NUM_SRC;
                        mdl_owner = -1;
                        nerr      = 1'b1;
                    end
                end
            end
            mdl_err = nerr;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((pending() || mdl_owner >= 0) && guard < 400) begin
            step();
            guard++;
        end
        chk("drain_bound", 32'(pending() || mdl_owner >= 0), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0; n_pushed = 0; n_popped = 0;
        for (int i = 0; i < NUM_SRC; i++) gap[i] = 1'b0;
        model_reset();
        rst_n       = 1'b0;
        bus.m_ready = 1'b1;

        // Reset state
        settle();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        advance();
        step();
        rst_n = 1'b1;

        // Single source: src1 sends 0x11, 0x22, 0x33
        add_beat(1, 8'h11, 1'b0);
        add_beat(1, 8'h22, 1'b0);
        add_beat(1, 8'h33, 1'b1);
        settle();
        chk("b_idle_busy", 32'(bus.busy), 32'd0);
        advance();
        for (int j = 0; j < 3; j++) begin
            settle();
            chk("b_grant", 32'(bus.grant_id), 32'd1);
            chk("b_data", 32'(bus.m_data), 32'(b_tab[j]));
            advance();
        end
        settle();
        chk("b_bubble_busy", 32'(bus.busy), 32'd0);
        chk("b_rr_ptr", 32'(dbg_rr_ptr), 32'd2);
        advance();

        // Fairness: all four sources offer single-beat packets from reset
        do_reset();
        for (int s = 0; s < NUM_SRC; s++) begin
            add_rand_pkt(s, 1);
            add_rand_pkt(s, 1);
        end
        for (int j = 0; j < 10; j++) begin
            settle();
            chk("c_busy", 32'(bus.busy), 32'(j % 2));
            if (j % 2 == 1) chk("c_grant_order", 32'(bus.grant_id), c_order[j/2]);
            advance();
        end
        drain();

        // Packet lock: src0 4-beat packet, src2 arrives at beat 2
        do_reset();
        for (int b = 0; b < 4; b++) add_beat(0, 8'(8'hD0 + b), (b == 3));
        step();
        settle();
        chk("d_grant0", 32'(bus.grant_id), 32'd0);
        advance();
        add_beat(2, 8'h2D, 1'b1);
        for (int j = 0; j < 3; j++) begin
            settle();
            chk("d_src2_ready", 32'(bus.s_ready[2]), 32'd0);
            chk("d_hold_grant", 32'(bus.grant_id), 32'd0);
            advance();
        end
        settle();
        chk("d_bubble", 32'(bus.busy), 32'd0);
        chk("d_no_timeout", 32'(bus.err_timeout), 32'd0);
        advance();
        settle();
        chk("d_grant2", 32'(bus.grant_id), 32'd2);
        chk("d_src2_ready_now", 32'(bus.s_ready[2]), 32'd1);
        advance();
        drain();

        // Backpressure on a 3-beat packet from src3
        add_beat(3, 8'hA1, 1'b0);
        add_beat(3, 8'hA2, 1'b0);
        add_beat(3, 8'hA3, 1'b1);
        bus.m_ready = 1'b1;
        step();
        for (int j = 0; j < 5; j++) begin
            bus.m_ready = e_rdy[j];
            settle();
            chk("e_data", 32'(bus.m_data), 32'(e_dat[j]));
            chk("e_s_ready3", 32'(bus.s_ready[3]), 32'(e_rdy[j]));
            chk("e_s_ready_other", 32'(bus.s_ready[2:0]), 32'd0);
            advance();
        end
        bus.m_ready = 1'b1;
        settle();
        chk("e_done", 32'(bus.busy), 32'd0);
        advance();

        // Watchdog: src2 streams without last, src3 waiting
        for (int b = 0; b < 6; b++) add_beat(2, 8'(8'hF0 + b), (b == 5));
        add_beat(3, 8'h3C, 1'b1);
        step();
        for (int j = 0; j < 4; j++) begin
            settle();
            chk("f_grant2", 32'(bus.grant_id), 32'd2);
            chk("f_no_err", 32'(bus.err_timeout), 32'd0);
            advance();
        end
        settle();
        chk("f_err_pulse", 32'(bus.err_timeout), 32'd1);
        chk("f_released", 32'(bus.busy), 32'd0);
        advance();
        settle();
        chk("f_err_once", 32'(bus.err_timeout), 32'd0);
        chk("f_grant3", 32'(bus.grant_id), 32'd3);
        advance();
        step();
        settle();
        chk("f_resume_grant", 32'(bus.grant_id), 32'd2);
        chk("f_resume_data", 32'(bus.m_data), 32'hF4);
        advance();
        drain();

        // Reset mid-packet during beat 2 of src1
        for (int b = 0; b < 4; b++) add_beat(1, 8'(8'hC0 + b), (b == 3));
        step();
        step();
        settle();
        chk("g_beat2", 32'(bus.m_data), 32'hC1);
        rst_n = 1'b0;
        #1;
        chk("g_rst_busy", 32'(bus.busy), 32'd0);
        chk("g_rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("g_rst_m_data", 32'(bus.m_data), 32'd0);
        chk("g_rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("g_rst_grant", 32'(bus.grant_id), 32'd0);
        chk("g_rst_err", 32'(bus.err_timeout), 32'd0);
        model_reset();
        n_pushed = n_pushed - exp_q[1].size();
        src_q[1].delete();
        exp_q[1].delete();
        @(negedge clk);
        cyc++;
        add_beat(0, 8'h0A, 1'b1);
        add_beat(1, 8'h1A, 1'b1);
        step();
        rst_n = 1'b1;
        settle();
        chk("g_idle", 32'(bus.busy), 32'd0);
        advance();
        settle();
        chk("g_src0_wins", 32'(bus.grant_id), 32'd0);
        advance();
        drain();

        // Randomized traffic with gaps and backpressure
        for (int r = 0; r < 800; r++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (src_q[s].size() == 0 && $urandom_range(0, 3) == 0)
                    add_rand_pkt(s, $urandom_range(1, 6));
                gap[s] = ($urandom_range(0, 4) == 0);
            end
            bus.m_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        for (int s = 0; s < NUM_SRC; s++) gap[s] = 1'b0;
        bus.m_ready = 1'b1;
        drain();
        step();

        chk("sb_all_beats", 32'(n_popped), 32'(n_pushed));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
